riscv_fetch_unit: RTL and testbench
===================================

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2, number of prefetch buffer entries (legal range 2..8).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-low.
REQ-005 imem_addr  output  32  byte address presented to instruction memory.
REQ-006 imem_data_in  input  4x8 unpacked byte array [0:3]  instruction memory read data; lane 0 is the least significant byte.
REQ-007 redirect_valid  input  1  core requests a fetch restart (taken branch or jump).
REQ-008 redirect_pc  input  32  restart target, sampled when redirect_valid=1.
REQ-009 halt  input  1  core requests that fetching stop.
REQ-010 inst_valid  output  1  head buffer entry is valid.
REQ-011 inst  output  32  head instruction {lane3,lane2,lane1,lane0}.
REQ-012 inst_pc  output  32  byte address of inst.
REQ-013 inst_ready  input  1  core accepts the head entry; transfer occurs when inst_valid & inst_ready.

Function
REQ-014 Instruction memory read latency is one cycle: data for the imem_addr driven in cycle N is sampled on imem_data_in in cycle N+1.
REQ-015 FSM states: IDLE, FETCH, HALTED; IDLE is the state out of reset and always advances to FETCH on the next edge.
REQ-016 In FETCH, a request issues in a cycle when (occupancy + in_flight - pop) < DEPTH; pop=1 when a transfer occurs that cycle.
REQ-017 Each issued request records its PC; on response, {pc, inst} is pushed to the buffer tail and fetch_pc advances by 4.
REQ-018 fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-019 imem_addr equals fetch_pc at all times, including cycles in which no request issues.
REQ-020 Buffer is FIFO ordered; simultaneous push and pop at full or empty is permitted and leaves occupancy unchanged.
REQ-021 Redirect has priority over all other activity: next cycle the buffer is empty, inst_valid=0, the in-flight response is discarded, and fetch_pc={redirect_pc[31:2],2'b00}.
REQ-022 A transfer in the same cycle as redirect_valid counts as accepted.
REQ-023 halt=1 in FETCH moves to HALTED; no new requests issue, the in-flight response is still pushed, and the buffer continues to drain.
REQ-024 HALTED returns to FETCH only on redirect_valid=1; halt and redirect in the same cycle: redirect applies, state becomes HALTED.
REQ-025 inst, inst_pc hold stable while inst_valid=1 and inst_ready=0.

Reset
REQ-026 On rst_b low: state=IDLE, fetch_pc=RESET_PC, occupancy=0, in_flight=0, inst_valid=0, inst=0, inst_pc=0.
REQ-027 Reset asserted mid-operation discards all buffered and in-flight instructions immediately; no output transfer is presented until fresh fetches complete.

Structure
REQ-028 Package riscv_pkg holds XLEN=32, INST_BYTES=4, the fetch FSM state enum, and the fetch entry struct {pc, inst}.
REQ-029 The prefetch buffer is one sub-module, riscv_fetch_fifo, parameterised by DEPTH, with push, pop, flush, full, empty and count ports.
REQ-030 Total RTL 120-400 lines; no combinational path from inst_ready to imem_addr other than the issue condition.

Verification
REQ-031 Reset release, inst_ready=1, memory words 0..3 = 0x00000013,0x00100093,0x00200113,0x00300193 -> first inst_valid in cycle 3 after reset with inst_pc=0, then one instruction per cycle, PCs 0,4,8,12.
REQ-032 inst_ready=0 for 10 cycles -> occupancy saturates at DEPTH, imem_addr holds at 4*DEPTH, no entry lost or duplicated after inst_ready rises.
REQ-033 redirect_valid with redirect_pc=0x0000_0102 while the buffer is full -> next cycle inst_valid=0, imem_addr=0x0000_0100, next delivered inst_pc=0x100.
REQ-034 RESET_PC=32'hFFFF_FFF8, free-running -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 halt pulse with one request in flight -> that instruction still delivered, no further fetches; redirect to 0x40 -> fetching resumes at 0x40.
REQ-036 rst_b low for one cycle mid-stream with buffer full -> inst_valid=0 immediately, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants, FSM states and buffer entry type for instruction fetch
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_FETCH  = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// rtl/riscv_fetch_fifo.sv - prefetch buffer holding {pc, inst} entries in fetch order
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch FSM with one-cycle memory and prefetch buffer
module riscv_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic [31:0] imem_addr,
  input  logic [7:0]  imem_data_in [0:3],
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          in_flight_q, in_flight_d;

  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          pop, push, issue, has_room;

  assign imem_addr  = fetch_pc_q;
  assign inst_valid = ~fifo_empty;
  assign inst       = fifo_empty ? '0 : head_entry.inst;
  assign inst_pc    = fifo_empty ? '0 : head_entry.pc;
  assign pop        = inst_valid & inst_ready;

  // A response arriving alongside a redirect belongs to the abandoned path.
  assign push            = in_flight_q & ~redirect_valid;
  assign push_entry.pc   = req_pc_q;
  assign push_entry.inst = {imem_data_in[3], imem_data_in[2], imem_data_in[1], imem_data_in[0]};

  // Room is reserved for the outstanding response so a push never meets a full buffer.
  assign has_room = ~(fifo_full & ~pop) &&
                    ((32'(fifo_count) + 32'(in_flight_q)) < (32'(DEPTH) + 32'(pop)));

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    in_flight_d = 1'b0;
    issue       = 1'b0;
    case (state_q)
      FS_IDLE: state_d = FS_FETCH;
      FS_FETCH: begin
        if (halt) begin
          state_d = FS_HALTED;
        end else if (!redirect_valid && has_room) begin
          issue = 1'b1;
        end
      end
      FS_HALTED: begin
        if (redirect_valid && !halt) begin
          state_d = FS_FETCH;
        end
      end
      default: state_d = FS_IDLE;
    endcase
    if (issue) begin
      in_flight_d = 1'b1;
      req_pc_d    = fetch_pc_q;
      fetch_pc_d  = fetch_pc_q + 32'(INST_BYTES);
    end
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= FS_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      in_flight_q <= in_flight_d;
    end
  end

  riscv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb/tb_riscv_fetch_unit.sv - self-checking bench for riscv_fetch_unit against a stream-level model
module tb_riscv_fetch_unit;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] imem_addr;
  logic [7:0]  imem_data_in [0:3];
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  logic [31:0] w_imem_addr;
  logic [7:0]  w_imem_data [0:3];
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_zero    = 1'b0;
  logic [31:0] w_zero_pc = 32'h0;
  logic        w_ready   = 1'b1;

  logic [31:0] rd_word;
  logic [31:0] w_rd_word;
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .imem_addr      (imem_addr),
    .imem_data_in   (imem_data_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  riscv_fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk            (clk),
    .rst_b          (rst_b),
    .imem_addr      (w_imem_addr),
    .imem_data_in   (w_imem_data),
    .redirect_valid (w_zero),
    .redirect_pc    (w_zero_pc),
    .halt           (w_zero),
    .inst_valid     (w_inst_valid),
    .inst           (w_inst),
    .inst_pc        (w_inst_pc),
    .inst_ready     (w_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0010_0093;
      32'h0000_0008: return 32'h0020_0113;
      32'h0000_000C: return 32'h0030_0193;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  // Synchronous instruction memory: address in cycle N, data in cycle N+1.
  always @(posedge clk) begin
    rd_word   <= mem_word(imem_addr);
    w_rd_word <= mem_word(w_imem_addr);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      imem_data_in[i] = rd_word[8*i +: 8];
      w_imem_data[i]  = w_rd_word[8*i +: 8];
    end
  end

  task automatic do_reset();
    rst_b          = 1'b0;
    inst_ready     = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset();
    rst_b          = 1'b0;
    inst_ready     = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    tests_run++;
    if (inst !== 32'h0) begin tests_failed++; $display("FAIL reset_inst: got %h expected 0", inst); end
    tests_run++;
    if (inst_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    tests_run++;
    if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    tests_run++;
    if (w_imem_addr !== WRAP_PC) begin tests_failed++; $display("FAIL reset_addr_wrap: got %h expected %h", w_imem_addr, WRAP_PC); end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    tests_run++;
    if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL idle_no_issue: got %h expected 0", imem_addr); end
    @(negedge clk);
    tests_run++;
    if (imem_addr !== 32'h4) begin tests_failed++; $display("FAIL first_issue_addr: got %h expected 4", imem_addr); end
  endtask

  task automatic test_first_fetch();
    logic [31:0] prog [4];
    prog = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    do_reset();
    inst_ready = 1'b1;
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL first_early_valid c%0d: got %b expected 0", n, inst_valid); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL first_valid c%0d: got %b expected 1", k + 3, inst_valid); end
      tests_run++;
      if (inst_pc !== 32'(4 * k)) begin tests_failed++; $display("FAIL first_pc c%0d: got %h expected %h", k + 3, inst_pc, 32'(4 * k)); end
      tests_run++;
      if (inst !== prog[k]) begin tests_failed++; $display("FAIL first_inst c%0d: got %h expected %h", k + 3, inst, prog[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    int got;
    do_reset();
    inst_ready = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        tests_run++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
          tests_failed++;
          $display("FAIL stall_hold c%0d: got valid=%b pc=%h expected valid=1 pc=0", c, inst_valid, inst_pc);
        end
      end
    end
    tests_run++;
    if (imem_addr !== 32'(4 * DEPTH)) begin tests_failed++; $display("FAIL stall_addr: got %h expected %h", imem_addr, 32'(4 * DEPTH)); end
    inst_ready = 1'b1;
    exp_pc = 32'h0;
    got    = 0;
    for (int c = 0; c < 20 && got < 8; c++) begin
      if (inst_valid) begin
        tests_run++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          tests_failed++;
          $display("FAIL drain_seq: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'h4;
        got++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (got != 8) begin tests_failed++; $display("FAIL drain_count: got %0d expected 8", got); end
  endtask

  task automatic test_redirect();
    logic found;
    do_reset();
    inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL redir_flush: got %b expected 0", inst_valid); end
    tests_run++;
    if (imem_addr !== 32'h100) begin tests_failed++; $display("FAIL redir_addr: got %h expected 100", imem_addr); end
    inst_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (inst_valid) found = 1'b1;
    end
    tests_run++;
    if (found !== 1'b1) begin tests_failed++; $display("FAIL redir_timeout: got %b expected 1", found); end
    tests_run++;
    if (inst_pc !== 32'h100 || inst !== mem_word(32'h100)) begin
      tests_failed++;
      $display("FAIL redir_first: got pc=%h inst=%h expected pc=100 inst=%h", inst_pc, inst, mem_word(32'h100));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_list [3];
    int got;
    exp_list = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    got = 0;
    for (int c = 0; c < 15 && got < 3; c++) begin
      @(negedge clk);
      if (w_inst_valid) begin
        tests_run++;
        if (w_inst_pc !== exp_list[got] || w_inst !== mem_word(exp_list[got])) begin
          tests_failed++;
          $display("FAIL wrap_seq: got pc=%h inst=%h expected pc=%h inst=%h", w_inst_pc, w_inst, exp_list[got], mem_word(exp_list[got]));
        end
        got++;
      end
    end
    tests_run++;
    if (got != 3) begin tests_failed++; $display("FAIL wrap_count: got %0d expected 3", got); end
  endtask

  task automatic test_halt();
    logic [31:0] exp_pc;
    logic [31:0] halt_addr;
    int got;
    do_reset();
    inst_ready = 1'b1;
    exp_pc     = 32'h0;
    // One request per cycle from the first FETCH cycle: after six edges 0..16 are issued.
    halt_addr  = 32'd20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        tests_run++;
        if (inst_pc !== exp_pc) begin tests_failed++; $display("FAIL halt_pre_seq: got %h expected %h", inst_pc, exp_pc); end
        exp_pc = exp_pc + 32'h4;
      end
    end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (inst_valid) begin
        tests_run++;
        if (inst_pc !== exp_pc) begin tests_failed++; $display("FAIL halt_drain_seq: got %h expected %h", inst_pc, exp_pc); end
        exp_pc = exp_pc + 32'h4;
      end
      tests_run++;
      if (imem_addr !== halt_addr) begin tests_failed++; $display("FAIL halt_addr_frozen: got %h expected %h", imem_addr, halt_addr); end
      @(negedge clk);
    end
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL halt_empty: got %b expected 0", inst_valid); end
    tests_run++;
    if (exp_pc !== halt_addr) begin tests_failed++; $display("FAIL halt_inflight_delivered: got next=%h expected %h", exp_pc, halt_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_pc = 32'h40;
    got    = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (inst_valid) begin
        tests_run++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          tests_failed++;
          $display("FAIL halt_resume_seq: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'h4;
        got++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (got != 3) begin tests_failed++; $display("FAIL halt_resume_count: got %0d expected 3", got); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] exp_pc;
    int got;
    do_reset();
    inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_full: got %b expected 1", inst_valid); end
    rst_b = 1'b0;
    #1;
    tests_run++;
    if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || imem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_async: got valid=%b pc=%h addr=%h expected 0 0 0", inst_valid, inst_pc, imem_addr);
    end
    @(negedge clk);
    rst_b      = 1'b1;
    inst_ready = 1'b1;
    exp_pc     = 32'h0;
    got        = 0;
    for (int c = 0; c < 10 && got < 4; c++) begin
      @(negedge clk);
      if (inst_valid) begin
        tests_run++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          tests_failed++;
          $display("FAIL mid_restart_seq: got pc=%h inst=%h expected pc=%h inst=%h", inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'h4;
        got++;
      end
    end
    tests_run++;
    if (got != 4) begin tests_failed++; $display("FAIL mid_restart_count: got %0d expected 4", got); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_inst, prev_pc;
    logic        prev_redir, prev_stall;
    int delivered;
    do_reset();
    exp_pc     = 32'h0;
    prev_redir = 1'b0;
    prev_stall = 1'b0;
    prev_inst  = 32'h0;
    prev_pc    = 32'h0;
    delivered  = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (prev_redir) begin
        tests_run++;
        if (inst_valid !== 1'b0) begin tests_failed++; $display("FAIL rnd_redir_flush c%0d: got %b expected 0", c, inst_valid); end
      end
      if (prev_stall) begin
        tests_run++;
        if (inst !== prev_inst || inst_pc !== prev_pc) begin
          tests_failed++;
          $display("FAIL rnd_stable c%0d: got pc=%h inst=%h expected pc=%h inst=%h", c, inst_pc, inst, prev_pc, prev_inst);
        end
      end
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom();
      halt           = ($urandom_range(0, 24) == 0);
      if (inst_valid && inst_ready) begin
        tests_run++;
        if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
          tests_failed++;
          $display("FAIL rnd_seq c%0d: got pc=%h inst=%h expected pc=%h inst=%h", c, inst_pc, inst, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'h4;
        delivered++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      prev_redir = redirect_valid;
      prev_stall = inst_valid && !inst_ready && !redirect_valid;
      prev_inst  = inst;
      prev_pc    = inst_pc;
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    halt           = 1'b0;
    inst_ready     = 1'b0;
    tests_run++;
    if (delivered < 60) begin tests_failed++; $display("FAIL rnd_progress: got %0d expected at least 60", delivered); end
  endtask

  initial begin
    rst_b          = 1'b0;
    inst_ready     = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
